// File: rtl/ofifo_drain_arbiter.sv
// ofifo_drain_arbiter
//   Read arbiter for a bank of `col` output FIFOs (one per PE column). It watches
//   the empty flags and pops at most one FIFO per cycle. Popped words go into a
//   single registered valid/ready output stage, tagged with their source column.
//   A drain request empties every FIFO and then pulses done. This block feeds
//   the psum SRAM write path.
//
//   Optional build macro: OFIFO_ROW_ORDER_EN
//     undefined : round-robin grant starting after the last granted column
//     defined   : strict row order. A row starts only when every FIFO holds a
//                 word. In DRAIN, partial rows are read in ascending column order.
//
// Ports
//   clk          single clock (the FIFOs' rd_clk is tied to it)
//   reset        synchronous, active-low
//   enable       permits new grants while running
//   drain        one-cycle request to empty all FIFOs and finish the tile
//   fifo_empty   per-column empty flags
//   fifo_data    per-column head words, column i at [i*bw +: bw]
//   fifo_rd      one-hot pop strobe (combinational)
//   out_data     registered popped word
//   out_col      registered source column of out_data
//   out_valid    out_data/out_col hold a word
//   out_ready    downstream accept
//   done         one-cycle pulse when a drain completes
//   busy         running with pending data, or draining
//   rd_count     number of pops since reset, wraps at 2^16
module ofifo_drain_arbiter #(
    parameter int col = 8,
    parameter int bw  = 16,
    parameter int cw  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              drain,
    input  logic [col-1:0]    fifo_empty,
    input  logic [col*bw-1:0] fifo_data,
    output logic [col-1:0]    fifo_rd,
    output logic [bw-1:0]     out_data,
    output logic [cw-1:0]     out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              busy,
    output logic [15:0]       rd_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

`ifdef OFIFO_ROW_ORDER_EN
    localparam logic [cw-1:0] PTR_RST = '0;
`else
    localparam logic [cw-1:0] PTR_RST = cw'(col - 1);
`endif

    state_t          state;
    // Round-robin mode: the last granted column.
    // Row-order mode: the next column expected in the current row.
    logic [cw-1:0]   ptr;
    logic [cw:0]     start;
    logic [cw-1:0]   grant;
    logic [cw-1:0]   hi_g, lo_g;
    logic            hi_ok, lo_ok, scan_ok, gnt_ok;
    logic [bw-1:0]   sel_data;
    logic            any_full, all_full, can_accept, run_ok, load;

    assign any_full   = ~&fifo_empty;
    assign all_full   = ~|fifo_empty;
    assign can_accept = ~out_valid | out_ready;
    assign run_ok     = ((state == RUN) & enable) | (state == DRAIN);

`ifdef OFIFO_ROW_ORDER_EN
    assign start  = {1'b0, ptr};
    // A new row (ptr == 0) needs every column filled, except while draining.
    assign gnt_ok = scan_ok & ((ptr != '0) | all_full | (state == DRAIN));
`else
    assign start  = {1'b0, ptr} + 1'b1;
    assign gnt_ok = scan_ok;
`endif

    // Two-pass priority scan: first the columns at or above `start`, then wrap
    // to the columns below it. Descending loops let the lowest index win.
    always_comb begin
        hi_ok    = 1'b0;
        lo_ok    = 1'b0;
        hi_g     = '0;
        lo_g     = '0;
        sel_data = '0;
        for (int i = col - 1; i >= 0; i--) begin
            if (!fifo_empty[i]) begin
                if (i >= int'(start)) begin
                    hi_ok = 1'b1;
                    hi_g  = cw'(i);
                end else begin
                    lo_ok = 1'b1;
                    lo_g  = cw'(i);
                end
            end
        end
        scan_ok = hi_ok | lo_ok;
        grant   = hi_ok ? hi_g : lo_g;
        for (int i = 0; i < col; i++) begin
            if (cw'(i) == grant) sel_data = fifo_data[i*bw +: bw];
        end
    end

    assign load    = reset & run_ok & gnt_ok & can_accept;
    assign fifo_rd = load ? ({{(col-1){1'b0}}, 1'b1} << grant) : '0;
    assign busy    = ((state == RUN) & any_full) | (state == DRAIN);

    // ---- output register stage and control FSM ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            done      <= 1'b0;
            rd_count  <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                out_data  <= sel_data;
                out_col   <= grant;
                out_valid <= 1'b1;
                rd_count  <= rd_count + 16'd1;
`ifdef OFIFO_ROW_ORDER_EN
                ptr       <= (grant == cw'(col - 1)) ? '0 : grant + 1'b1;
`else
                ptr       <= grant;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (drain)       state <= DRAIN;
                    else if (enable) state <= RUN;
                end
                RUN: begin
                    if (drain)                        state <= DRAIN;
                    else if (!enable && can_accept)   state <= IDLE;
                end
                DRAIN: begin
                    // Finished once nothing is left upstream and the output
                    // register is empty or being emptied without a reload.
                    if (!any_full && (!out_valid || (out_ready && !load))) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
